// File: rtl/complex_nr_mult_seq.sv
// Sequential complex multiplier: (a+ib)(c+id) using one shared multiplier over four cycles.
// Optional build macro COMPLEX_NR_MULT_SIGNED_EN selects two's-complement operands (default unsigned).
module complex_nr_mult_seq #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic                              sw_rst,
   input  logic                              op_val,
   output logic                              op_ready,
   input  logic [4*DATA_WIDTH-1:0]           op_data,
   output logic                              res_val,
   input  logic                              res_ready,
   output logic [2*(2*DATA_WIDTH+1)-1:0]     res_data
);

   localparam int RES_WIDTH = 2*DATA_WIDTH + 1;

   typedef enum logic [2:0] {
      IDLE,
      P_AC,
      P_BD,
      P_AD,
      P_BC,
      DONE
   } state_t;

   state_t                  state_q;
   state_t                  state_nx;
   logic                    op_ready_q;
   logic                    res_val_q;
   logic [DATA_WIDTH-1:0]   a_q;
   logic [DATA_WIDTH-1:0]   b_q;
   logic [DATA_WIDTH-1:0]   c_q;
   logic [DATA_WIDTH-1:0]   d_q;
   logic [RES_WIDTH-1:0]    re_acc;
   logic [RES_WIDTH-1:0]    im_acc;
   logic [DATA_WIDTH-1:0]   mul_x;
   logic [DATA_WIDTH-1:0]   mul_y;
   logic [2*DATA_WIDTH-1:0] prod_raw;
   logic [RES_WIDTH-1:0]    prod_ext;

   always_comb begin
      state_nx = state_q;
      case (state_q)
         IDLE:    if (op_val) state_nx = P_AC;
         P_AC:    state_nx = P_BD;
         P_BD:    state_nx = P_AD;
         P_AD:    state_nx = P_BC;
         P_BC:    state_nx = DONE;
         DONE:    if (res_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state so they change on the same edge as the FSM.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         op_ready_q <= 1'b1;
         res_val_q  <= 1'b0;
      end else if (sw_rst) begin
         state_q    <= IDLE;
         op_ready_q <= 1'b1;
         res_val_q  <= 1'b0;
      end else begin
         state_q    <= state_nx;
         op_ready_q <= (state_nx == IDLE);
         res_val_q  <= (state_nx == DONE);
      end
   end

   always_comb begin
      mul_x = a_q;
      mul_y = c_q;
      case (state_q)
         P_AC: begin mul_x = a_q; mul_y = c_q; end
         P_BD: begin mul_x = b_q; mul_y = d_q; end
         P_AD: begin mul_x = a_q; mul_y = d_q; end
         P_BC: begin mul_x = b_q; mul_y = c_q; end
         default: begin mul_x = a_q; mul_y = c_q; end
      endcase
   end

`ifdef COMPLEX_NR_MULT_SIGNED_EN
   assign prod_raw = $signed({{DATA_WIDTH{mul_x[DATA_WIDTH-1]}}, mul_x})
                   * $signed({{DATA_WIDTH{mul_y[DATA_WIDTH-1]}}, mul_y});
   assign prod_ext = {prod_raw[2*DATA_WIDTH-1], prod_raw};
`else
   assign prod_raw = {{DATA_WIDTH{1'b0}}, mul_x} * {{DATA_WIDTH{1'b0}}, mul_y};
   assign prod_ext = {1'b0, prod_raw};
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         a_q    <= '0;
         b_q    <= '0;
         c_q    <= '0;
         d_q    <= '0;
         re_acc <= '0;
         im_acc <= '0;
      end else if (sw_rst) begin
         a_q    <= '0;
         b_q    <= '0;
         c_q    <= '0;
         d_q    <= '0;
         re_acc <= '0;
         im_acc <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (op_val) begin
                  a_q <= op_data[4*DATA_WIDTH-1:3*DATA_WIDTH];
                  b_q <= op_data[3*DATA_WIDTH-1:2*DATA_WIDTH];
                  c_q <= op_data[2*DATA_WIDTH-1:DATA_WIDTH];
                  d_q <= op_data[DATA_WIDTH-1:0];
               end
            end
            P_AC:    re_acc <= prod_ext;
            P_BD:    re_acc <= re_acc - prod_ext;
            P_AD:    im_acc <= prod_ext;
            P_BC:    im_acc <= im_acc + prod_ext;
            default: ;
         endcase
      end
   end

   assign op_ready = op_ready_q;
   assign res_val  = res_val_q;
   assign res_data = {re_acc, im_acc};

endmodule
